pipe_reg_de: RTL and testbench

- Decode-to-Execute pipeline register of the 5-stage MIPS core; sits directly upstream of the Execute-to-Memory control register and feeds the E stage.
- Captures D-stage operands, immediate, PC/instruction, destination register, control bits and T_new.
- Supports bubble insertion (clr), freeze (hold) and a W-stage write-capture bypass, so operands in E are never stale.

---
 rtl/pipe_reg_de.sv | 133 +++++++++++++
 tb/tb_pipe_reg_de.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_de.sv
// Decode-to-Execute pipeline register with W-stage write capture on the operands.
// Latency 1 cycle; hold freezes E (operand capture still active), clr loads a bubble.
module pipe_reg_de #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          hold,
  input  logic [DW-1:0] pc_D,
  input  logic [DW-1:0] instr_D,
  input  logic [DW-1:0] rs_data_D,
  input  logic [DW-1:0] rt_data_D,
  input  logic [DW-1:0] imm_ext_D,
  input  logic [RW-1:0] rs_D,
  input  logic [RW-1:0] rt_D,
  input  logic [RW-1:0] wreg_D,
  input  logic          regw_D,
  input  logic          memtoreg_D,
  input  logic          memw_D,
  input  logic          memr_D,
  input  logic          jjal_D,
  input  logic          alu_src_D,
  input  logic [3:0]    alu_op_D,
  input  logic [2:0]    T_new_D,
  input  logic          valid_D,
  input  logic          regw_W,
  input  logic [RW-1:0] wreg_W,
  input  logic [DW-1:0] wdata_W,
  output logic [DW-1:0] pc_E,
  output logic [DW-1:0] instr_E,
  output logic [DW-1:0] rs_data_E,
  output logic [DW-1:0] rt_data_E,
  output logic [DW-1:0] imm_ext_E,
  output logic [RW-1:0] rs_E,
  output logic [RW-1:0] rt_E,
  output logic [RW-1:0] wreg_E,
  output logic          regw_E,
  output logic          memtoreg_E,
  output logic          memw_E,
  output logic          memr_E,
  output logic          jjal_E,
  output logic          alu_src_E,
  output logic          valid_E,
  output logic [3:0]    alu_op_E,
  output logic [2:0]    T_new_E
);

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] instr;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm_ext;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] wreg;
    logic          regw;
    logic          memtoreg;
    logic          memw;
    logic          memr;
    logic          jjal;
    logic          alu_src;
    logic          valid;
    logic [3:0]    alu_op;
    logic [2:0]    t_new;
  } de_t;

  de_t de_q, de_d;

  // $0 is hard-wired, so a W write to index 0 never counts as a hit.
  logic w_act;
  logic rs_hit_ld, rt_hit_ld, rs_hit_hd, rt_hit_hd;

  assign w_act     = regw_W && (wreg_W != '0);
  assign rs_hit_ld = w_act && (wreg_W == rs_D);
  assign rt_hit_ld = w_act && (wreg_W == rt_D);
  assign rs_hit_hd = w_act && (wreg_W == de_q.rs) && de_q.valid;
  assign rt_hit_hd = w_act && (wreg_W == de_q.rt) && de_q.valid;

  always_comb begin
    de_d = de_q;
    if (clr) begin
      de_d = '0;
    end else if (hold) begin
      if (rs_hit_hd) de_d.rs_data = wdata_W;
      if (rt_hit_hd) de_d.rt_data = wdata_W;
    end else begin
      de_d.pc       = pc_D;
      de_d.instr    = instr_D;
      de_d.rs_data  = rs_hit_ld ? wdata_W : rs_data_D;
      de_d.rt_data  = rt_hit_ld ? wdata_W : rt_data_D;
      de_d.imm_ext  = imm_ext_D;
      de_d.rs       = rs_D;
      de_d.rt       = rt_D;
      de_d.wreg     = wreg_D;
      de_d.regw     = regw_D;
      de_d.memtoreg = memtoreg_D;
      de_d.memw     = memw_D;
      de_d.memr     = memr_D;
      de_d.jjal     = jjal_D;
      de_d.alu_src  = alu_src_D;
      de_d.valid    = valid_D;
      de_d.alu_op   = alu_op_D;
      de_d.t_new    = (T_new_D != 3'd0) ? (T_new_D - 3'd1) : 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) de_q <= '0;
    else        de_q <= de_d;
  end

  assign pc_E       = de_q.pc;
  assign instr_E    = de_q.instr;
  assign rs_data_E  = de_q.rs_data;
  assign rt_data_E  = de_q.rt_data;
  assign imm_ext_E  = de_q.imm_ext;
  assign rs_E       = de_q.rs;
  assign rt_E       = de_q.rt;
  assign wreg_E     = de_q.wreg;
  assign regw_E     = de_q.regw;
  assign memtoreg_E = de_q.memtoreg;
  assign memw_E     = de_q.memw;
  assign memr_E     = de_q.memr;
  assign jjal_E     = de_q.jjal;
  assign alu_src_E  = de_q.alu_src;
  assign valid_E    = de_q.valid;
  assign alu_op_E   = de_q.alu_op;
  assign T_new_E    = de_q.t_new;

endmodule

// File: tb/tb_pipe_reg_de.sv
// Directed bench for pipe_reg_de: reset, T_new saturation, clr/hold priority, W capture.
module tb_pipe_reg_de;

  logic        clk = 1'b0;
  logic        rst_n, clr, hold;
  logic [31:0] pc_D, instr_D, rs_data_D, rt_data_D, imm_ext_D;
  logic [4:0]  rs_D, rt_D, wreg_D;
  logic        regw_D, memtoreg_D, memw_D, memr_D, jjal_D, alu_src_D, valid_D;
  logic [3:0]  alu_op_D;
  logic [2:0]  T_new_D;
  logic        regw_W;
  logic [4:0]  wreg_W;
  logic [31:0] wdata_W;
  logic [31:0] pc_E, instr_E, rs_data_E, rt_data_E, imm_ext_E;
  logic [4:0]  rs_E, rt_E, wreg_E;
  logic        regw_E, memtoreg_E, memw_E, memr_E, jjal_E, alu_src_E, valid_E;
  logic [3:0]  alu_op_E;
  logic [2:0]  T_new_E;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_reg_de #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .hold(hold),
    .pc_D(pc_D), .instr_D(instr_D), .rs_data_D(rs_data_D), .rt_data_D(rt_data_D),
    .imm_ext_D(imm_ext_D), .rs_D(rs_D), .rt_D(rt_D), .wreg_D(wreg_D),
    .regw_D(regw_D), .memtoreg_D(memtoreg_D), .memw_D(memw_D), .memr_D(memr_D),
    .jjal_D(jjal_D), .alu_src_D(alu_src_D), .alu_op_D(alu_op_D), .T_new_D(T_new_D),
    .valid_D(valid_D), .regw_W(regw_W), .wreg_W(wreg_W), .wdata_W(wdata_W),
    .pc_E(pc_E), .instr_E(instr_E), .rs_data_E(rs_data_E), .rt_data_E(rt_data_E),
    .imm_ext_E(imm_ext_E), .rs_E(rs_E), .rt_E(rt_E), .wreg_E(wreg_E),
    .regw_E(regw_E), .memtoreg_E(memtoreg_E), .memw_E(memw_E), .memr_E(memr_E),
    .jjal_E(jjal_E), .alu_src_E(alu_src_E), .valid_E(valid_E), .alu_op_E(alu_op_E),
    .T_new_E(T_new_E)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // One rising edge, then return on the falling edge where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; hold = 1'b0;
    pc_D = '0; instr_D = '0; rs_data_D = '0; rt_data_D = '0; imm_ext_D = '0;
    rs_D = '0; rt_D = '0; wreg_D = '0;
    regw_D = 0; memtoreg_D = 0; memw_D = 0; memr_D = 0; jjal_D = 0; alu_src_D = 0;
    valid_D = 0; alu_op_D = '0; T_new_D = '0;
    regw_W = 0; wreg_W = '0; wdata_W = '0;

    @(negedge clk);
    chk("rst_pc", pc_E, 32'h0);
    chk("rst_valid", {31'h0, valid_E}, 32'h0);
    rst_n = 1'b1;

    // Load a full instruction, then reset asynchronously mid-cycle.
    pc_D = 32'h1234; instr_D = 32'hCAFE; imm_ext_D = 32'h55; valid_D = 1; regw_D = 1;
    wreg_D = 5'd7; alu_op_D = 4'h9; T_new_D = 3'd3; rs_data_D = 32'h66;
    tick();
    chk("ld_pc", pc_E, 32'h1234);
    chk("ld_instr", instr_E, 32'hCAFE);
    chk("ld_alu_op", {28'h0, alu_op_E}, 32'h9);
    chk("ld_wreg", {27'h0, wreg_E}, 32'h7);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_pc", pc_E, 32'h0);
    chk("arst_valid", {31'h0, valid_E}, 32'h0);
    chk("arst_regw", {31'h0, regw_E}, 32'h0);
    chk("arst_tnew", {29'h0, T_new_E}, 32'h0);
    chk("arst_rs_data", rs_data_E, 32'h0);
    #1 rst_n = 1'b1;
    pc_D = 32'h3000; T_new_D = 3'd2; valid_D = 1;
    tick();
    chk("post_rst_pc", pc_E, 32'h3000);
    chk("post_rst_tnew", {29'h0, T_new_E}, 32'h1);
    chk("post_rst_valid", {31'h0, valid_E}, 32'h1);

    // T_new saturates at 0.
    T_new_D = 3'd0; tick(); chk("tnew_0", {29'h0, T_new_E}, 32'h0);
    T_new_D = 3'd1; tick(); chk("tnew_1", {29'h0, T_new_E}, 32'h0);
    T_new_D = 3'd3; tick(); chk("tnew_3", {29'h0, T_new_E}, 32'h2);
    T_new_D = 3'd7; tick(); chk("tnew_7", {29'h0, T_new_E}, 32'h6);

    // clr wins over hold and over the incoming instruction.
    pc_D = 32'h40; regw_D = 1; valid_D = 1; wreg_D = 5'd5; T_new_D = 3'd2;
    clr = 1; hold = 1;
    tick();
    chk("clr_valid", {31'h0, valid_E}, 32'h0);
    chk("clr_regw", {31'h0, regw_E}, 32'h0);
    chk("clr_wreg", {27'h0, wreg_E}, 32'h0);
    chk("clr_pc", pc_E, 32'h0);
    chk("clr_tnew", {29'h0, T_new_E}, 32'h0);
    clr = 0; hold = 0;

    // Load-time capture of the W write.
    rs_D = 5'd8; rs_data_D = 32'h11; rt_D = 5'd3; rt_data_D = 32'h22;
    regw_W = 1; wreg_W = 5'd8; wdata_W = 32'hAB;
    tick();
    chk("ldbyp_rs", rs_data_E, 32'hAB);
    chk("ldbyp_rt_nohit", rt_data_E, 32'h22);
    rt_D = 5'd0; rt_data_D = 32'h0; wreg_W = 5'd0; wdata_W = 32'h77;
    tick();
    chk("ldbyp_r0_rt", rt_data_E, 32'h0);
    chk("ldbyp_r0_rs", rs_data_E, 32'h11);
    rs_D = 5'd4; rt_D = 5'd4; rs_data_D = 32'h1; rt_data_D = 32'h2;
    wreg_W = 5'd4; wdata_W = 32'hBEEF;
    tick();
    chk("ldbyp_both_rs", rs_data_E, 32'hBEEF);
    chk("ldbyp_both_rt", rt_data_E, 32'hBEEF);
    regw_W = 0;
    tick();
    chk("ldbyp_noregw_rs", rs_data_E, 32'h1);
    chk("ldbyp_noregw_rt", rt_data_E, 32'h2);

    // Hold with W draining into E's rt operand.
    rs_D = 5'd1; rs_data_D = 32'h10; rt_D = 5'd9; rt_data_D = 32'h5;
    pc_D = 32'h100; T_new_D = 3'd3; valid_D = 1;
    tick();
    chk("hld_pre_rt", rt_data_E, 32'h5);
    hold = 1; pc_D = 32'h999; T_new_D = 3'd0; rt_data_D = 32'h77;
    tick();
    chk("hld_c1_rt", rt_data_E, 32'h5);
    chk("hld_c1_pc", pc_E, 32'h100);
    regw_W = 1; wreg_W = 5'd9; wdata_W = 32'hDEAD;
    tick();
    chk("hld_c2_rt", rt_data_E, 32'hDEAD);
    chk("hld_c2_rs", rs_data_E, 32'h10);
    chk("hld_c2_tnew", {29'h0, T_new_E}, 32'h2);
    regw_W = 0;
    tick();
    chk("hld_c3_rt", rt_data_E, 32'hDEAD);
    chk("hld_c3_pc", pc_E, 32'h100);
    chk("hld_c3_tnew", {29'h0, T_new_E}, 32'h2);
    hold = 0;

    // Same sequence, but E holds an invalid entry: no capture.
    rt_D = 5'd9; rt_data_D = 32'h0; valid_D = 0; pc_D = 32'h200; T_new_D = 3'd2;
    tick();
    hold = 1;
    tick();
    regw_W = 1; wreg_W = 5'd9; wdata_W = 32'hDEAD;
    tick();
    chk("bub_c2_rt", rt_data_E, 32'h0);
    regw_W = 0;
    tick();
    chk("bub_c3_rt", rt_data_E, 32'h0);
    chk("bub_c3_pc", pc_E, 32'h200);
    chk("bub_c3_tnew", {29'h0, T_new_E}, 32'h1);
    hold = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
